fifo_cond: RTL and testbench

- Synchronous FIFO that serves as the responder endpoint of the arbiter's push/pop handshake.
- Used on both sides of the arbiter:
  - Input side (p0..p3): the arbiter samples empty, pops, and reads data combinationally.
  - Output side (p0..p3): the arbiter writes data2send_cond under push and throttles on almost_full.
- Word format is fixed: [9:8] destination, [7:0] payload. Four instances per side.

---
 rtl/fifo_cond.sv | 88 ++++++++
 tb/tb_fifo_cond.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/fifo_cond.sv
// First-word-fall-through synchronous FIFO used as the push/pop responder on both
// sides of the arbiter; words are {dest[1:0], payload[7:0]}.
module fifo_cond #(
    parameter int DATA_WIDTH = 10,
    parameter int ADDR_WIDTH = 3,
    parameter int AF_THRESH  = 6,
    parameter int AE_THRESH  = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic                  pop,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  empty,
    output logic                  full,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [ADDR_WIDTH-1:0] r_wr_ptr;
    logic [ADDR_WIDTH-1:0] r_rd_ptr;
    logic [ADDR_WIDTH:0]   r_count;
    logic                  r_overflow;
    logic                  r_underflow;

    logic w_empty;
    logic w_full;
    logic w_push_ok;
    logic w_pop_ok;

    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == (ADDR_WIDTH+1)'(DEPTH));
    assign w_pop_ok  = pop && !w_empty;
    // When full, a pop in the same cycle is necessarily accepted and frees the slot.
    assign w_push_ok = push && (!w_full || pop);

    // Storage has no reset; stale words are never visible because data_out is gated by empty.
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= data_in;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_push_ok && !w_pop_ok) begin
                r_count <= r_count + 1'b1;
            end else if (w_pop_ok && !w_push_ok) begin
                r_count <= r_count - 1'b1;
            end
            if (push && !w_push_ok) begin
                r_overflow <= 1'b1;
            end
            if (pop && !w_pop_ok) begin
                r_underflow <= 1'b1;
            end
        end
    end

    assign data_out     = w_empty ? '0 : r_mem[r_rd_ptr];
    assign count        = r_count;
    assign empty        = w_empty;
    assign full         = w_full;
    assign almost_full  = (r_count >= (ADDR_WIDTH+1)'(AF_THRESH));
    assign almost_empty = (r_count <= (ADDR_WIDTH+1)'(AE_THRESH));
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;

endmodule

// File: tb/tb_fifo_cond.sv
// Directed, table-driven bench for fifo_cond: per-cycle vectors with hand-computed
// occupancy, head word and flags, plus hand-written reset and feed-through sequences.
module tb_fifo_cond;

    logic       clk;
    logic       reset;
    logic       push;
    logic       pop;
    logic [9:0] data_in;
    logic [9:0] data_out;
    logic [3:0] count;
    logic       empty;
    logic       full;
    logic       almost_full;
    logic       almost_empty;
    logic       overflow;
    logic       underflow;

    fifo_cond dut (
        .clk          (clk),
        .reset        (reset),
        .push         (push),
        .pop          (pop),
        .data_in      (data_in),
        .data_out     (data_out),
        .count        (count),
        .empty        (empty),
        .full         (full),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // flags = {empty, full, almost_full, almost_empty, overflow, underflow}
    typedef struct packed {
        logic       push;
        logic       pop;
        logic [9:0] din;
        logic [3:0] cnt;
        logic [9:0] dout;
        logic [5:0] flags;
    } vec_t;

    localparam int NV = 26;
    vec_t vecs [NV];

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [19:0] act, input logic [19:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got {count,data_out,flags}=%05h required %05h", name, act, exp);
        end
    endtask

    function automatic logic [19:0] observed();
        return {count, data_out, empty, full, almost_full, almost_empty, overflow, underflow};
    endfunction

    initial begin
        vecs[0]  = '{1'b1, 1'b0, 10'h101, 4'd1, 10'h101, 6'b000100};
        vecs[1]  = '{1'b1, 1'b0, 10'h2A5, 4'd2, 10'h101, 6'b000100};
        vecs[2]  = '{1'b1, 1'b0, 10'h3FF, 4'd3, 10'h101, 6'b000000};
        vecs[3]  = '{1'b0, 1'b1, 10'h000, 4'd2, 10'h2A5, 6'b000100};
        vecs[4]  = '{1'b0, 1'b1, 10'h000, 4'd1, 10'h3FF, 6'b000100};
        vecs[5]  = '{1'b0, 1'b1, 10'h000, 4'd0, 10'h000, 6'b100100};
        vecs[6]  = '{1'b1, 1'b0, 10'h000, 4'd1, 10'h000, 6'b000100};
        vecs[7]  = '{1'b1, 1'b0, 10'h001, 4'd2, 10'h000, 6'b000100};
        vecs[8]  = '{1'b1, 1'b0, 10'h002, 4'd3, 10'h000, 6'b000000};
        vecs[9]  = '{1'b1, 1'b0, 10'h003, 4'd4, 10'h000, 6'b000000};
        vecs[10] = '{1'b1, 1'b0, 10'h004, 4'd5, 10'h000, 6'b000000};
        vecs[11] = '{1'b1, 1'b0, 10'h005, 4'd6, 10'h000, 6'b001000};
        vecs[12] = '{1'b1, 1'b0, 10'h006, 4'd7, 10'h000, 6'b001000};
        vecs[13] = '{1'b1, 1'b0, 10'h007, 4'd8, 10'h000, 6'b011000};
        vecs[14] = '{1'b1, 1'b0, 10'h3AA, 4'd8, 10'h000, 6'b011010};
        vecs[15] = '{1'b1, 1'b1, 10'h1C3, 4'd8, 10'h001, 6'b011010};
        vecs[16] = '{1'b0, 1'b1, 10'h000, 4'd7, 10'h002, 6'b001010};
        vecs[17] = '{1'b0, 1'b1, 10'h000, 4'd6, 10'h003, 6'b001010};
        vecs[18] = '{1'b0, 1'b1, 10'h000, 4'd5, 10'h004, 6'b000010};
        vecs[19] = '{1'b0, 1'b1, 10'h000, 4'd4, 10'h005, 6'b000010};
        vecs[20] = '{1'b0, 1'b1, 10'h000, 4'd3, 10'h006, 6'b000010};
        vecs[21] = '{1'b0, 1'b1, 10'h000, 4'd2, 10'h007, 6'b000110};
        vecs[22] = '{1'b0, 1'b1, 10'h000, 4'd1, 10'h1C3, 6'b000110};
        vecs[23] = '{1'b0, 1'b1, 10'h000, 4'd0, 10'h000, 6'b100110};
        vecs[24] = '{1'b0, 1'b1, 10'h000, 4'd0, 10'h000, 6'b100111};
        vecs[25] = '{1'b1, 1'b1, 10'h0F0, 4'd1, 10'h0F0, 6'b000111};

        reset   = 1'b1;
        push    = 1'b0;
        pop     = 1'b0;
        data_in = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("reset_idle", observed(), {4'd0, 10'h000, 6'b100100});

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            push    = vecs[i].push;
            pop     = vecs[i].pop;
            data_in = vecs[i].din;
            @(posedge clk);
            #1;
            check($sformatf("vec%0d", i), observed(), {vecs[i].cnt, vecs[i].dout, vecs[i].flags});
        end

        // Fill to 5 words, then reset asynchronously between edges.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            push    = 1'b1;
            pop     = 1'b0;
            data_in = 10'h200 + 10'(i);
            @(posedge clk);
        end
        @(negedge clk);
        push = 1'b0;
        #1;
        check("five_words", observed(), {4'd5, 10'h0F0, 6'b000011});
        #1;
        reset = 1'b1;
        #1;
        check("async_reset", observed(), {4'd0, 10'h000, 6'b100100});
        @(negedge clk);
        reset = 1'b0;

        // Data presented while empty without push must not reach data_out.
        data_in = 10'h155;
        #1;
        check("no_feedthrough", observed(), {4'd0, 10'h000, 6'b100100});

        @(negedge clk);
        push    = 1'b1;
        data_in = 10'h2B4;
        @(posedge clk);
        #1;
        check("push_after_reset", observed(), {4'd1, 10'h2B4, 6'b000100});

        @(negedge clk);
        push = 1'b0;
        pop  = 1'b1;
        @(posedge clk);
        #1;
        check("pop_after_reset", observed(), {4'd0, 10'h000, 6'b100100});
        @(negedge clk);
        pop = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
